// File: rtl/arb_rsp_router_if.sv
// Bundles the arbitrated request path, downstream port and response fan-out of arb_rsp_router.
// The slave modport is the router's view; the master modport is the surrounding fabric's view.
interface arb_rsp_router_if #(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned ReqWidth = 32,
    parameter int unsigned RspWidth = 32,
    parameter int unsigned MaxTrans = 4
);
    localparam int unsigned IdxWidth = $clog2(NumIn);
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    logic                req_i;
    logic                gnt_o;
    logic [ReqWidth-1:0] data_i;
    logic [IdxWidth-1:0] idx_i;
    logic                req_o;
    logic                gnt_i;
    logic [ReqWidth-1:0] data_o;
    logic                rsp_valid_i;
    logic                rsp_ready_o;
    logic [RspWidth-1:0] rsp_data_i;
    logic [NumIn-1:0]    rsp_valid_o;
    logic [NumIn-1:0]    rsp_ready_i;
    logic [RspWidth-1:0] rsp_data_o;
    logic [CntWidth-1:0] outstanding_o;
    logic                busy_o;

    modport slave (
        input  req_i, data_i, idx_i, gnt_i, rsp_valid_i, rsp_data_i, rsp_ready_i,
        output gnt_o, req_o, data_o, rsp_ready_o, rsp_valid_o, rsp_data_o,
               outstanding_o, busy_o
    );

    modport master (
        output req_i, data_i, idx_i, gnt_i, rsp_valid_i, rsp_data_i, rsp_ready_i,
        input  gnt_o, req_o, data_o, rsp_ready_o, rsp_valid_o, rsp_data_o,
               outstanding_o, busy_o
    );
endinterface

// File: rtl/arb_rsp_router.sv
// Tracks arbitrated requests in an in-order index FIFO and routes each response back to its issuer.
// Latency: request 0 cycles (1 with ARB_RSP_ROUTER_SPILL_EN defined), response 0 cycles.
// Backpressure: full FIFO drops gnt_o; response ready follows the head issuer's ready, low when empty.
module arb_rsp_router #(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned ReqWidth = 32,
    parameter int unsigned RspWidth = 32,
    parameter int unsigned MaxTrans = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    arb_rsp_router_if.slave bus
);
    localparam int unsigned IdxWidth = $clog2(NumIn);
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxTrans - 1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(MaxTrans);

    logic [IdxWidth-1:0] idx_mem [MaxTrans];
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr;
    logic [CntWidth-1:0] cnt;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [IdxWidth-1:0] head;
    logic [ReqWidth-1:0] req_dat;
    logic [RspWidth-1:0] rsp_dat;

    // Explicit wrap so non-power-of-two depths never walk past the last entry.
    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full  = (cnt == CntFull);
    assign empty = (cnt == '0);
    assign head  = idx_mem[rd_ptr];
    assign push  = bus.req_i & bus.gnt_o;
    assign pop   = bus.rsp_valid_i & bus.rsp_ready_o;

`ifdef ARB_RSP_ROUTER_SPILL_EN
    logic spill_vld;

    // Full is taken from the registered count only, so no rsp_* path reaches gnt_o.
    assign bus.gnt_o  = ~full & (~spill_vld | bus.gnt_i);
    assign bus.req_o  = spill_vld;
    assign bus.data_o = req_dat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spill_vld <= 1'b0;
            req_dat   <= '0;
        end else if (flush_i) begin
            spill_vld <= 1'b0;
        end else if (push) begin
            spill_vld <= 1'b1;
            req_dat   <= bus.data_i;
        end else if (bus.gnt_i) begin
            spill_vld <= 1'b0;
        end
    end
`else
    assign req_dat    = bus.data_i;
    assign bus.gnt_o  = bus.gnt_i & ~full;
    assign bus.req_o  = bus.req_i & ~full;
    assign bus.data_o = req_dat;
`endif

    always_comb begin
        bus.rsp_valid_o = '0;
        if (bus.rsp_valid_i && !empty) begin
            bus.rsp_valid_o[head] = 1'b1;
        end
    end

    assign bus.rsp_ready_o   = bus.rsp_ready_i[head] & ~empty;
    assign rsp_dat           = bus.rsp_data_i;
    assign bus.rsp_data_o    = rsp_dat;
    assign bus.outstanding_o = cnt;
    assign bus.busy_o        = ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + CntWidth'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CntWidth'(1);
            end
        end
    end

    // Index storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem[wr_ptr] <= bus.idx_i;
        end
    end

    a_no_rsp_when_empty : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(bus.rsp_valid_i && empty)
    ) else $error("response arrived with no outstanding transaction");
endmodule

// File: tb/tb_arb_rsp_router.sv
// Directed plus randomized bench for arb_rsp_router against a queue-based reference model.
module tb_arb_rsp_router;
    localparam int NumIn    = 4;
    localparam int ReqWidth = 32;
    localparam int RspWidth = 32;
    localparam int MaxTrans = 4;
    localparam int IdxW     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [IdxW-1:0]     mq[$];
    bit                  m_sv = 1'b0;
    logic [ReqWidth-1:0] m_sd = '0;
    bit                  acc_req = 1'b0;
    bit                  acc_rsp = 1'b0;

    always #5 clk = ~clk;

    arb_rsp_router_if #(
        .NumIn(NumIn), .ReqWidth(ReqWidth), .RspWidth(RspWidth), .MaxTrans(MaxTrans)
    ) bus ();

    arb_rsp_router #(
        .NumIn(NumIn), .ReqWidth(ReqWidth), .RspWidth(RspWidth), .MaxTrans(MaxTrans)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_full();
        return mq.size() == MaxTrans;
    endfunction

    function automatic bit exp_gnt();
`ifdef ARB_RSP_ROUTER_SPILL_EN
        return !m_full() && (!m_sv || bus.gnt_i);
`else
        return !m_full() && bus.gnt_i;
`endif
    endfunction

    function automatic bit exp_req();
`ifdef ARB_RSP_ROUTER_SPILL_EN
        return m_sv;
`else
        return bus.req_i && !m_full();
`endif
    endfunction

    function automatic logic [ReqWidth-1:0] exp_data();
`ifdef ARB_RSP_ROUTER_SPILL_EN
        return m_sd;
`else
        return bus.data_i;
`endif
    endfunction

    function automatic bit exp_rsp_rdy();
        if (mq.size() == 0) return 1'b0;
        return bus.rsp_ready_i[mq[0]];
    endfunction

    function automatic logic [NumIn-1:0] exp_rsp_vld();
        logic [NumIn-1:0] v;
        v = '0;
        if (bus.rsp_valid_i && mq.size() > 0) v[mq[0]] = 1'b1;
        return v;
    endfunction

    // Reference model: an in-order queue of issuer indices plus an optional one-entry buffer.
    initial begin
        bit p;
        bit q;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_sv    = 1'b0;
                acc_req = 1'b0;
                acc_rsp = 1'b0;
            end else begin
                p = bus.req_i && exp_gnt();
                q = bus.rsp_valid_i && exp_rsp_rdy();
                acc_req = p;
                acc_rsp = q;
                if (flush) begin
                    mq.delete();
                    m_sv = 1'b0;
                end else begin
`ifdef ARB_RSP_ROUTER_SPILL_EN
                    if (p) begin
                        m_sv = 1'b1;
                        m_sd = bus.data_i;
                    end else if (bus.gnt_i) begin
                        m_sv = 1'b0;
                    end
`endif
                    if (q) void'(mq.pop_front());
                    if (p) mq.push_back(bus.idx_i);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("gnt_o", 64'(bus.gnt_o), 64'(exp_gnt()));
            chk("req_o", 64'(bus.req_o), 64'(exp_req()));
            if (exp_req()) chk("data_o", 64'(bus.data_o), 64'(exp_data()));
            chk("rsp_valid_o", 64'(bus.rsp_valid_o), 64'(exp_rsp_vld()));
            chk("rsp_ready_o", 64'(bus.rsp_ready_o), 64'(exp_rsp_rdy()));
            chk("rsp_data_o", 64'(bus.rsp_data_o), 64'(bus.rsp_data_i));
            chk("outstanding_o", 64'(bus.outstanding_o), 64'(mq.size()));
            chk("busy_o", 64'(bus.busy_o), 64'(mq.size() != 0));
        end
    end

    initial begin
        logic [IdxW-1:0]     ord [4] = '{2'd3, 2'd0, 2'd1, 2'd3};
        logic [NumIn-1:0]    ordv[4] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};
        logic [ReqWidth-1:0] dat [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

        bus.req_i       = 1'b0;
        bus.data_i      = '0;
        bus.idx_i       = '0;
        bus.gnt_i       = 1'b1;
        bus.rsp_valid_i = 1'b0;
        bus.rsp_data_i  = '0;
        bus.rsp_ready_i = '1;

        #2;
        chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_ready", 64'(bus.rsp_ready_o), 64'd0);
        chk("rst_req_o", 64'(bus.req_o), 64'd0);
        step();
        step();
        rst_n = 1'b1;

`ifdef ARB_RSP_ROUTER_SPILL_EN
        step();
        bus.req_i = 1'b1; bus.data_i = dat[0]; bus.gnt_i = 1'b1;
        #1;
        chk("spill_first_gnt", 64'(bus.gnt_o), 64'd1);
        chk("spill_first_req", 64'(bus.req_o), 64'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            bus.data_i = dat[k]; bus.rsp_valid_i = 1'b1;
            #1;
            chk("spill_b2b_req", 64'(bus.req_o), 64'd1);
            chk("spill_b2b_data", 64'(bus.data_o), 64'(dat[k-1]));
            chk("spill_b2b_cnt", 64'(bus.outstanding_o), 64'd1);
        end
        step();
        bus.req_i = 1'b0;
        #1;
        chk("spill_last_data", 64'(bus.data_o), 64'h44);
        step();
        bus.rsp_valid_i = 1'b0; bus.req_i = 1'b1; bus.data_i = 32'h55; bus.gnt_i = 1'b0;
        #1;
        chk("spill_gnt_empty", 64'(bus.gnt_o), 64'd1);
        chk("spill_req_empty", 64'(bus.req_o), 64'd0);
        step();
        bus.data_i = 32'h66;
        #1;
        chk("spill_gnt_filled", 64'(bus.gnt_o), 64'd0);
        chk("spill_data_held", 64'(bus.data_o), 64'h55);
        step();
        bus.gnt_i = 1'b1;
        #1;
        chk("spill_gnt_drain", 64'(bus.gnt_o), 64'd1);
        step();
        bus.req_i = 1'b0; bus.rsp_valid_i = 1'b1;
        #1;
        chk("spill_data_next", 64'(bus.data_o), 64'h66);
        chk("spill_cnt2", 64'(bus.outstanding_o), 64'd2);
        step();
        step();
        bus.rsp_valid_i = 1'b0;
        #1;
        chk("spill_cnt0", 64'(bus.outstanding_o), 64'd0);
`else
        // Single transaction
        step();
        bus.req_i = 1'b1; bus.idx_i = 2'd2; bus.data_i = 32'hA5; bus.gnt_i = 1'b1;
        #1;
        chk("single_req_o", 64'(bus.req_o), 64'd1);
        chk("single_data_o", 64'(bus.data_o), 64'hA5);
        chk("single_gnt_o", 64'(bus.gnt_o), 64'd1);
        step();
        bus.req_i = 1'b0;
        #1;
        chk("single_cnt1", 64'(bus.outstanding_o), 64'd1);
        chk("single_busy", 64'(bus.busy_o), 64'd1);
        bus.rsp_valid_i = 1'b1; bus.rsp_data_i = 32'h5A; bus.rsp_ready_i = 4'b0100;
        #1;
        chk("single_rsp_valid", 64'(bus.rsp_valid_o), 64'b0100);
        chk("single_rsp_ready", 64'(bus.rsp_ready_o), 64'd1);
        chk("single_rsp_data", 64'(bus.rsp_data_o), 64'h5A);
        step();
        bus.rsp_valid_i = 1'b0;
        #1;
        chk("single_cnt0", 64'(bus.outstanding_o), 64'd0);

        // Ordering
        for (int i = 0; i < 4; i++) begin
            step();
            bus.req_i = 1'b1; bus.idx_i = ord[i];
        end
        step();
        bus.req_i = 1'b0; bus.rsp_ready_i = '1;
        #1;
        chk("order_cnt4", 64'(bus.outstanding_o), 64'd4);
        for (int k = 0; k < 4; k++) begin
            bus.rsp_valid_i = 1'b1; bus.rsp_data_i = 32'(k);
            #1;
            chk("order_rsp_valid", 64'(bus.rsp_valid_o), 64'(ordv[k]));
            step();
        end
        bus.rsp_valid_i = 1'b0;
        // Brief mid-cycle probe of a stray response; withdrawn before the next edge.
        bus.rsp_valid_i = 1'b1;
        #1;
        chk("order_5th_ready", 64'(bus.rsp_ready_o), 64'd0);
        chk("order_5th_valid", 64'(bus.rsp_valid_o), 64'd0);
        bus.rsp_valid_i = 1'b0;

        // Full
        for (int k = 0; k < 4; k++) begin
            step();
            bus.req_i = 1'b1; bus.idx_i = 2'(k);
        end
        step();
        bus.idx_i = 2'd1;
        #1;
        chk("full_gnt", 64'(bus.gnt_o), 64'd0);
        chk("full_req", 64'(bus.req_o), 64'd0);
        chk("full_cnt", 64'(bus.outstanding_o), 64'd4);
        bus.rsp_valid_i = 1'b1; bus.rsp_ready_i = '1;
        #1;
        chk("full_pop_ready", 64'(bus.rsp_ready_o), 64'd1);
        chk("full_pop_gnt", 64'(bus.gnt_o), 64'd0);
        chk("full_pop_req", 64'(bus.req_o), 64'd0);
        step();
        bus.rsp_valid_i = 1'b0;
        #1;
        chk("full_after_gnt", 64'(bus.gnt_o), 64'd1);
        chk("full_after_cnt", 64'(bus.outstanding_o), 64'd3);
        step();
        bus.req_i = 1'b0;

        // Backpressure: queue now holds 1,2,3,1
        bus.rsp_ready_i = 4'b1101; bus.rsp_valid_i = 1'b1;
        #1;
        chk("bp_ready", 64'(bus.rsp_ready_o), 64'd0);
        chk("bp_valid", 64'(bus.rsp_valid_o), 64'b0010);
        step();
        chk("bp_cnt_held", 64'(bus.outstanding_o), 64'd4);
        bus.rsp_ready_i = 4'b1111;
        #1;
        chk("bp_ready_rise", 64'(bus.rsp_ready_o), 64'd1);
        step();
        chk("bp_cnt_pop", 64'(bus.outstanding_o), 64'd3);
        step();
        step();
        step();
        bus.rsp_valid_i = 1'b0;
        #1;
        chk("bp_drained", 64'(bus.outstanding_o), 64'd0);

        // Flush with a simultaneous push
        for (int k = 0; k < 3; k++) begin
            step();
            bus.req_i = 1'b1; bus.idx_i = 2'(k);
        end
        step();
        bus.idx_i = 2'd3; flush = 1'b1;
        #1;
        chk("flush_pre_cnt", 64'(bus.outstanding_o), 64'd3);
        step();
        flush = 1'b0; bus.req_i = 1'b0;
        #1;
        chk("flush_cnt", 64'(bus.outstanding_o), 64'd0);
        chk("flush_busy", 64'(bus.busy_o), 64'd0);

        // Asynchronous reset mid-stream
        step();
        bus.req_i = 1'b1;
        step();
        step();
        bus.req_i = 1'b0;
        #1;
        chk("arst_pre_cnt", 64'(bus.outstanding_o), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(bus.outstanding_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        step();
        rst_n = 1'b1;
`endif

        // Randomized traffic obeying the stable-until-granted rule in both directions.
        for (int c = 0; c < 3000; c++) begin
            step();
            flush = ($urandom_range(0, 63) == 0);
            if (!(bus.req_i && !acc_req)) begin
                bus.req_i  = ($urandom_range(0, 2) != 0);
                bus.data_i = $urandom;
                bus.idx_i  = 2'($urandom_range(0, NumIn - 1));
            end
            bus.gnt_i       = ($urandom_range(0, 3) != 0);
            bus.rsp_ready_i = 4'($urandom);
            if (!(bus.rsp_valid_i && !acc_rsp && mq.size() > 0)) begin
                bus.rsp_valid_i = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
                bus.rsp_data_i  = $urandom;
            end
        end
        step();
        flush = 1'b0; bus.req_i = 1'b0; bus.rsp_valid_i = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
